param_memory: RTL and testbench

PARAM_MEMORY -- requirements
Module: param_memory

---
 rtl/param_memory.sv | 123 ++++++++++++
 tb/tb_param_memory.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/param_memory.sv
// param_memory: single-port-write / single-port-read word memory with a
// power-up zeroing sweep.  After reset the FSM walks every word writing zero
// (busy=1), then services independent read and write requests.  Read data is
// registered (one-cycle latency) and qualified by rvalid.
// Optional feature: define PARAM_MEMORY_BYPASS_EN to forward write data to a
// same-cycle, same-address read; otherwise such a read returns the old word.
module param_memory #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ren,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  din,
    output logic [WIDTH-1:0]  dout,
    output logic              rvalid,
    output logic              busy
);

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_e;

    // One extra bit so DEPTH == 2**ADDR_W is representable in the compare.
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

`ifdef PARAM_MEMORY_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [WIDTH-1:0]  mem_q [DEPTH];

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] init_ptr_q, init_ptr_d;
    logic [WIDTH-1:0]  dout_q, dout_d;
    logic              rvalid_q, rvalid_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WIDTH-1:0]  mem_wdata;
    logic              raddr_ok;
    logic              waddr_ok;

    assign raddr_ok = ({1'b0, raddr} < DEPTH_EXT);
    assign waddr_ok = ({1'b0, waddr} < DEPTH_EXT);

    // Next-state, sweep pointer, read result and memory write port selection.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        dout_d     = '0;
        rvalid_d   = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = waddr;
        mem_wdata  = din;

        case (state_q)
            INIT: begin
                mem_we    = 1'b1;
                mem_waddr = init_ptr_q;
                mem_wdata = '0;
                if (init_ptr_q == LAST_ADDR) begin
                    state_d    = READY;
                    init_ptr_d = '0;
                end else begin
                    init_ptr_d = init_ptr_q + 1'b1;
                end
            end
            READY: begin
                mem_we   = wen && waddr_ok;
                rvalid_d = ren;
                if (ren && raddr_ok) begin
                    if (BYPASS && wen && (waddr == raddr)) begin
                        dout_d = din;
                    end else begin
                        dout_d = mem_q[raddr];
                    end
                end
            end
            default: state_d = INIT;
        endcase
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q    <= INIT;
            init_ptr_q <= '0;
            dout_q     <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
            dout_q     <= dout_d;
            rvalid_q   <= rvalid_d;
        end
    end

    // Storage array: written by the sweep or by accepted writes, never in reset.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset term so it maps onto RAM; the INIT sweep
        // is what clears it.
        if (rst_n && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign dout   = dout_q;
    assign rvalid = rvalid_q;
    assign busy   = (state_q == INIT);

endmodule

// File: tb/tb_param_memory.sv
// Self-checking bench for param_memory.  Two instances run side by side:
// default geometry (128 words) and a short one (100 words, 7-bit address)
// that exercises out-of-range addresses.  A behavioural array model predicts
// busy/dout/rvalid after every edge; directed phases add spec constants.
module tb_param_memory;

    localparam int N = 2;

`ifdef PARAM_MEMORY_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ren    [N];
    logic [6:0] raddr  [N];
    logic       wen    [N];
    logic [6:0] waddr  [N];
    logic [7:0] din    [N];
    logic [7:0] dout   [N];
    logic       rvalid [N];
    logic       busy   [N];

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state.
    int         depth_of [N] = '{128, 100};
    logic [7:0] model_mem [N][128];
    int         init_left [N];
    logic [7:0] exp_dout  [N];
    logic       exp_rv    [N];
    int         busy_cnt  [N];

    always #5 clk = ~clk;

    param_memory #(.WIDTH(8), .DEPTH(128), .ADDR_W(7)) u_dut_full (
        .clk(clk), .rst_n(rst_n),
        .ren(ren[0]), .raddr(raddr[0]), .wen(wen[0]), .waddr(waddr[0]),
        .din(din[0]), .dout(dout[0]), .rvalid(rvalid[0]), .busy(busy[0])
    );

    param_memory #(.WIDTH(8), .DEPTH(100), .ADDR_W(7)) u_dut_short (
        .clk(clk), .rst_n(rst_n),
        .ren(ren[1]), .raddr(raddr[1]), .wen(wen[1]), .waddr(waddr[1]),
        .din(din[1]), .dout(dout[1]), .rvalid(rvalid[1]), .busy(busy[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle_all();
        for (int i = 0; i < N; i++) begin
            ren[i] = 1'b0; raddr[i] = '0; wen[i] = 1'b0; waddr[i] = '0; din[i] = '0;
        end
    endtask

    task automatic set_io(input int i, input logic r, input int ra,
                          input logic w, input int wa, input logic [7:0] d);
        ren[i] = r; raddr[i] = 7'(ra); wen[i] = w; waddr[i] = 7'(wa); din[i] = d;
    endtask

    // One clock: advance the model at the edge, compare at the falling edge.
    task automatic step();
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (!rst_n) begin
                init_left[i] = depth_of[i];
                for (int a = 0; a < 128; a++) model_mem[i][a] = 8'h00;
                exp_dout[i] = 8'h00;
                exp_rv[i]   = 1'b0;
            end else if (init_left[i] > 0) begin
                init_left[i]--;
                exp_dout[i] = 8'h00;
                exp_rv[i]   = 1'b0;
            end else begin
                exp_rv[i]   = ren[i];
                exp_dout[i] = 8'h00;
                if (ren[i] && int'(raddr[i]) < depth_of[i])
                    exp_dout[i] = (BYPASS && wen[i] && waddr[i] == raddr[i])
                                  ? din[i] : model_mem[i][raddr[i]];
                if (wen[i] && int'(waddr[i]) < depth_of[i])
                    model_mem[i][waddr[i]] = din[i];
            end
        end
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(init_left[i] > 0));
            check($sformatf("rvalid[%0d]", i), 32'(rvalid[i]), 32'(exp_rv[i]));
            check($sformatf("dout[%0d]", i), 32'(dout[i]), 32'(exp_dout[i]));
        end
    endtask

    // Reset for one edge, then count busy cycles while hammering addr 20
    // with writes and reads that must be ignored.
    task automatic do_reset();
        idle_all();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) busy_cnt[i] = 0;
        for (int c = 0; c < 300; c++) begin
            if (!busy[0] && !busy[1]) break;
            for (int i = 0; i < N; i++) begin
                if (busy[i]) busy_cnt[i]++;
                set_io(i, busy[i], 20, busy[i], 20, 8'hFF);
            end
            step();
        end
        idle_all();
        for (int i = 0; i < N; i++)
            check($sformatf("busy_cycles[%0d]", i), 32'(busy_cnt[i]), 32'(depth_of[i]));
    endtask

    initial begin
        idle_all();
        rst_n = 1'b0;
        step();

        // Sweep length, writes during busy ignored, all words read as zero.
        do_reset();
        for (int a = 0; a < 128; a++) begin
            for (int i = 0; i < N; i++) set_io(i, 1'b1, a, 1'b0, 0, 8'h00);
            step();
            check("zero_read", 32'(dout[0]), 32'h00);
            check("zero_rvalid", 32'(rvalid[0]), 32'h1);
        end

        // Write 5 then read it back, then an idle cycle.
        for (int i = 0; i < N; i++) set_io(i, 1'b0, 0, 1'b1, 5, 8'hA5);
        step();
        for (int i = 0; i < N; i++) set_io(i, 1'b1, 5, 1'b0, 0, 8'h00);
        step();
        check("rd5_data", 32'(dout[0]), 32'hA5);
        check("rd5_valid", 32'(rvalid[0]), 32'h1);
        idle_all();
        step();
        check("idle_data", 32'(dout[0]), 32'h00);
        check("idle_valid", 32'(rvalid[0]), 32'h0);

        // Same-address read and write.
        for (int i = 0; i < N; i++) set_io(i, 1'b0, 0, 1'b1, 9, 8'h11);
        step();
        for (int i = 0; i < N; i++) set_io(i, 1'b1, 9, 1'b1, 9, 8'h3C);
        step();
        check("collide_data", 32'(dout[0]), BYPASS ? 32'h3C : 32'h11);
        for (int i = 0; i < N; i++) set_io(i, 1'b1, 9, 1'b0, 0, 8'h00);
        step();
        check("after_collide", 32'(dout[0]), 32'h3C);

        // Out-of-range addresses on the 100-word instance; word 99 works.
        for (int i = 0; i < N; i++) set_io(i, 1'b0, 0, 1'b1, 110, 8'h55);
        step();
        for (int i = 0; i < N; i++) set_io(i, 1'b1, 110, 1'b1, 99, 8'h5A);
        step();
        check("oor_data", 32'(dout[1]), 32'h00);
        check("oor_valid", 32'(rvalid[1]), 32'h1);
        for (int i = 0; i < N; i++) set_io(i, 1'b1, 99, 1'b0, 0, 8'h00);
        step();
        check("last_word", 32'(dout[1]), 32'h5A);
        idle_all();

        // Randomized traffic with occasional reset pulses (mid-INIT too).
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 399) != 0);
            for (int i = 0; i < N; i++) begin
                int ra;
                ra = $urandom_range(0, 127);
                set_io(i, 1'($urandom), ra, 1'($urandom),
                       ($urandom_range(0, 3) == 0) ? ra : $urandom_range(0, 127),
                       8'($urandom));
            end
            step();
        end
        rst_n = 1'b1;
        idle_all();
        do_reset();

        // Reset pulse mid-READY wipes earlier contents.
        for (int i = 0; i < N; i++) set_io(i, 1'b0, 0, 1'b1, 3, 8'h77);
        step();
        do_reset();
        for (int i = 0; i < N; i++) set_io(i, 1'b1, 3, 1'b0, 0, 8'h00);
        step();
        check("rd3_after_rst", 32'(dout[0]), 32'h00);
        check("rd3_valid", 32'(rvalid[0]), 32'h1);
        idle_all();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
